wb_router: RTL and testbench



---
 rtl/wb_router_if.sv | 43 ++++
 rtl/wb_router.sv | 140 ++++++++++++++
 tb/tb_wb_router.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_router_if.sv
// wb_router_if: Wishbone classic signals between one master, the router
// and PORTS slaves. The master side is point to point. The slave side
// carries one cyc/stb/ack lane per port and a packed read-data vector.
interface wb_router_if #(
  parameter int PORTS = 16
);
  logic                  m_cyc;
  logic                  m_stb;
  logic                  m_we;
  logic [3:0]            m_sel;
  logic [31:0]           m_adr;
  logic [31:0]           m_dat_i;
  logic [31:0]           m_dat_o;
  logic                  m_ack;
  logic                  m_err;

  logic [PORTS-1:0]      s_cyc;
  logic [PORTS-1:0]      s_stb;
  logic                  s_we;
  logic [3:0]            s_sel;
  logic [31:0]           s_adr;
  logic [31:0]           s_dat_o;
  logic [32*PORTS-1:0]   s_dat_i;
  logic [PORTS-1:0]      s_ack;

  // The CPU or upstream bus issuing requests.
  modport master (
    output m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_i,
    input  m_dat_o, m_ack, m_err
  );

  // The population of downstream slaves.
  modport slave (
    input  s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o,
    output s_dat_i, s_ack
  );

  // The router sits between the two sides.
  modport router (
    input  m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_i, s_dat_i, s_ack,
    output m_dat_o, m_ack, m_err, s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o
  );
endinterface

// File: rtl/wb_router.sv
// wb_router: Wishbone classic 1-to-PORTS router. It decodes the port from an
// address field and forwards the cycle to that slave. Accesses to ports that
// are not populated, and slaves that never acknowledge, end in an error
// termination. Each such fault is recorded in the fault_* registers.
module wb_router #(
  parameter int               PORTS   = 16,
  parameter int               BASE    = 28,
  parameter logic [PORTS-1:0] MAP     = {PORTS{1'b1}},
  parameter int               TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wb_router_if.router bus,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_adr,
  output logic [7:0]  fault_count
);

  localparam int          SELW          = $clog2(PORTS);
  localparam logic [15:0] WD_LAST       = 16'(TIMEOUT - 1);
  localparam logic [1:0]  CODE_UNMAPPED = 2'b01;
  localparam logic [1:0]  CODE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SELW-1:0] r_port;
  logic [SELW-1:0] w_reqPort;
  logic [15:0]     r_wd;
  logic [1:0]      r_code;
  logic [1:0]      w_errCode;
  logic [31:0]     r_adr;
  logic            w_req;

  assign w_req       = bus.m_cyc & bus.m_stb;
  assign w_reqPort   = bus.m_adr[BASE+SELW-1:BASE];

  assign bus.s_we    = bus.m_we;
  assign bus.s_sel   = bus.m_sel;
  assign bus.s_adr   = bus.m_adr;
  assign bus.s_dat_o = bus.m_dat_i;

  // State register; reset drops any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture port and address at decode, and run the watchdog while forwarding.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_port <= '0;
      r_adr  <= '0;
      r_wd   <= '0;
      r_code <= '0;
    end else begin
      if (r_state == ST_IDLE && w_req) begin
        r_port <= w_reqPort;
        r_adr  <= bus.m_adr;
        r_wd   <= '0;
      end else if (r_state == ST_FWD) begin
        r_wd <= r_wd + 16'd1;
      end
      if (w_next == ST_ERR) begin
        r_code <= w_errCode;
      end
    end
  end

  // Fault log is written as the ERR cycle closes; the counter saturates.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fault_code  <= '0;
      fault_adr   <= '0;
      fault_count <= '0;
    end else if (r_state == ST_ERR) begin
      fault_code <= r_code;
      fault_adr  <= r_adr;
      if (fault_count != 8'hFF) begin
        fault_count <= fault_count + 8'd1;
      end
    end
  end

  // Next-state decode plus the combinational routing of strobes, ack and data.
  always_comb begin
    w_next      = r_state;
    w_errCode   = CODE_UNMAPPED;
    bus.s_cyc   = '0;
    bus.s_stb   = '0;
    bus.m_ack   = 1'b0;
    bus.m_err   = 1'b0;
    bus.m_dat_o = '0;
    fault       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (MAP[w_reqPort]) begin
            w_next = ST_FWD;
          end else begin
            w_next    = ST_ERR;
            w_errCode = CODE_UNMAPPED;
          end
        end
      end
      ST_FWD: begin
        bus.s_cyc[r_port] = bus.m_cyc;
        bus.s_stb[r_port] = bus.m_stb;
        bus.m_ack         = bus.s_ack[r_port];
        bus.m_dat_o       = bus.s_dat_i[{r_port, 5'd0} +: 32];
        if (bus.s_ack[r_port]) begin
          w_next = ST_IDLE;
        end else if (!bus.m_cyc) begin
          w_next = ST_IDLE;
        end else if (r_wd == WD_LAST) begin
          w_next    = ST_ERR;
          w_errCode = CODE_TIMEOUT;
        end
      end
      ST_ERR: begin
        bus.m_err = bus.m_cyc;
        fault     = 1'b1;
        w_next    = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_router.sv
// tb_wb_router: scoreboard bench for wb_router. It uses 16 ports, only the
// low 8 populated, and a watchdog of 4 cycles. Slave models acknowledge
// after a per-port number of strobe cycles, or never. Port 2 asserts ack
// constantly, so stray acks from unselected ports are exercised.
`timescale 1ns/1ps
module tb_wb_router;

  localparam int          PORTS   = 16;
  localparam int          BASE    = 28;
  localparam int          TIMEOUT = 4;
  localparam logic [15:0] MAP_P   = 16'h00FF;
  localparam int          NEVER   = 1000;

  typedef struct {
    logic        isErr;
    logic [1:0]  code;
    logic [31:0] data;
    int          lat;
    int          stbCycles;
    logic [15:0] stbMask;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] fault_adr;
  logic [7:0]  fault_count;

  wb_router_if #(.PORTS(PORTS)) bus ();

  wb_router #(
    .PORTS  (PORTS),
    .BASE   (BASE),
    .MAP    (MAP_P),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bus        (bus),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_adr  (fault_adr),
    .fault_count(fault_count)
  );

  int          checks     = 0;
  int          failures   = 0;
  int          cycleCount = 0;
  int          slaveCnt   [PORTS];
  int          slaveDelay [PORTS];
  logic [31:0] slaveData  [PORTS];
  logic [15:0] rogue      = 16'h0004;
  exp_t        expQ[$];

  logic [7:0]  modelCount;
  logic [1:0]  modelCode;
  logic [31:0] modelAdr;

  int          reqCycle  = 0;
  int          stbCycles = 0;
  int          stbFirst  = 0;
  logic [15:0] stbMask   = '0;

  always #5 clk_i = ~clk_i;

  // Cycle counter and per-slave wait-state counters.
  always @(posedge clk_i) begin
    cycleCount <= cycleCount + 1;
    for (int p = 0; p < PORTS; p++) begin
      if (bus.s_stb[p] && !bus.s_ack[p]) slaveCnt[p] <= slaveCnt[p] + 1;
      else slaveCnt[p] <= 0;
    end
  end

  // Slave read data, always presented on every port.
  always_comb begin
    bus.s_dat_i = '0;
    for (int p = 0; p < PORTS; p++) bus.s_dat_i[32*p +: 32] = slaveData[p];
  end

  // Slave acks after the configured number of wait states.
  always_comb begin
    bus.s_ack = rogue;
    for (int p = 0; p < PORTS; p++) begin
      if (bus.s_stb[p] && slaveCnt[p] == slaveDelay[p]) bus.s_ack[p] = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic exp_t predict(input logic [31:0] adr);
    exp_t        e;
    logic [15:0] mapBits;
    int          p;
    int          d;
    mapBits = MAP_P;
    p = int'(adr[31:28]);
    d = slaveDelay[p];
    if (!mapBits[p]) begin
      e.isErr = 1'b1; e.code = 2'b01; e.data = '0; e.lat = 1;
      e.stbCycles = 0; e.stbMask = '0;
    end else if (d < TIMEOUT) begin
      e.isErr = 1'b0; e.code = 2'b00; e.data = slaveData[p]; e.lat = d + 1;
      e.stbCycles = d + 1; e.stbMask = 16'h0001 << p;
    end else begin
      e.isErr = 1'b1; e.code = 2'b10; e.data = '0; e.lat = TIMEOUT + 1;
      e.stbCycles = TIMEOUT; e.stbMask = 16'h0001 << p;
    end
    return e;
  endfunction

  // Called at posedge+1 with the router idle. Returns at posedge+1 of the
  // cycle after the termination, with the request dropped.
  task automatic applyStimulus(input logic [31:0] adr, input logic we,
                               input logic [31:0] wdata, input logic [3:0] sel);
    exp_t e;
    logic done;
    e = predict(adr);
    expQ.push_back(e);
    if (e.isErr) begin
      modelCount = (modelCount == 8'hFF) ? 8'hFF : modelCount + 8'd1;
      modelCode  = e.code;
      modelAdr   = adr;
    end
    stbCycles   = 0;
    stbFirst    = 0;
    stbMask     = '0;
    reqCycle    = cycleCount;
    bus.m_adr   = adr;
    bus.m_we    = we;
    bus.m_dat_i = wdata;
    bus.m_sel   = sel;
    bus.m_cyc   = 1'b1;
    bus.m_stb   = 1'b1;
    #1;
    checkOutput("passAdr", bus.s_adr, adr);
    checkOutput("passDat", bus.s_dat_o, wdata);
    checkOutput("passCtl", {bus.s_we, bus.s_sel}, {we, sel});
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk_i);
      done = bus.m_ack || bus.m_err;
    end
    if (!done) checkOutput("respBound", 0, 1);
    @(posedge clk_i);
    #1;
    checkOutput("faultCode", fault_code, modelCode);
    checkOutput("faultAdr", fault_adr, modelAdr);
    checkOutput("faultCount", fault_count, modelCount);
    bus.m_cyc = 1'b0;
    bus.m_stb = 1'b0;
  endtask

  // Response monitor: accumulates strobe activity and scores each termination.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (bus.s_stb != '0) begin
        if (stbCycles == 0) stbFirst = cycleCount - reqCycle;
        stbCycles++;
        stbMask |= bus.s_stb;
      end
      if (bus.m_ack || bus.m_err) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedResp", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("respErr", bus.m_err, e.isErr);
          checkOutput("respAck", bus.m_ack, !e.isErr);
          checkOutput("respData", bus.m_dat_o, e.data);
          checkOutput("respFault", fault, e.isErr);
          checkOutput("respLatency", cycleCount - reqCycle, e.lat);
          checkOutput("stbCycles", stbCycles, e.stbCycles);
          checkOutput("stbMask", stbMask, e.stbMask);
          if (e.stbCycles > 0) checkOutput("stbStart", stbFirst, 1);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL globalTimeout: observed no finish expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin : main
    int pulses;
    rst_i       = 1'b0;
    bus.m_cyc   = 1'b0;
    bus.m_stb   = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_sel   = 4'h0;
    bus.m_adr   = '0;
    bus.m_dat_i = '0;
    modelCount  = '0;
    modelCode   = '0;
    modelAdr    = '0;
    for (int p = 0; p < PORTS; p++) begin
      slaveData[p]  = 32'h5100_0000 + 32'(p) * 32'h0001_0101;
      slaveDelay[p] = NEVER;
    end
    slaveData[3]  = 32'hDEAD_BEEF;
    slaveDelay[0] = 0;
    slaveDelay[1] = 1;
    slaveDelay[3] = 2;
    slaveDelay[4] = 4;
    slaveDelay[5] = 3;

    #3;
    checkOutput("rst.faultCount", fault_count, 8'h00);
    checkOutput("rst.faultCode", fault_code, 2'b00);
    checkOutput("rst.faultAdr", fault_adr, 32'h0);
    checkOutput("rst.sStb", bus.s_stb, 16'h0);
    checkOutput("rst.mOut", {bus.m_ack, bus.m_err, fault}, 3'b000);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    $display("[TB] directed transfers");
    applyStimulus(32'h3000_0010, 1'b0, 32'h0, 4'hF);
    applyStimulus(32'h0000_0100, 1'b0, 32'h0, 4'hF);
    applyStimulus(32'h0000_0104, 1'b1, 32'h1234_5678, 4'h3);
    applyStimulus(32'h1000_0008, 1'b1, 32'hCAFE_F00D, 4'hC);
    applyStimulus(32'h9000_0000, 1'b0, 32'h0, 4'hF);
    applyStimulus(32'hF000_0040, 1'b1, 32'h0BAD_0BAD, 4'h1);
    applyStimulus(32'h6000_0000, 1'b0, 32'h0, 4'hF);
    applyStimulus(32'h3000_0020, 1'b0, 32'h0, 4'hF);
    applyStimulus(32'h5000_0000, 1'b0, 32'h0, 4'hF);
    applyStimulus(32'h4000_0000, 1'b0, 32'h0, 4'hF);
    applyStimulus(32'h7000_000C, 1'b1, 32'h7777_0000, 4'hF);
    applyStimulus(32'h0000_0200, 1'b0, 32'h0, 4'hF);

    $display("[TB] error with cyc already low");
    bus.m_adr = 32'hA000_0004;
    bus.m_cyc = 1'b1;
    bus.m_stb = 1'b1;
    modelCount = (modelCount == 8'hFF) ? 8'hFF : modelCount + 8'd1;
    modelCode  = 2'b01;
    modelAdr   = 32'hA000_0004;
    @(posedge clk_i); #1;
    bus.m_cyc = 1'b0;
    bus.m_stb = 1'b0;
    @(negedge clk_i);
    checkOutput("errCycLow.mErr", bus.m_err, 1'b0);
    checkOutput("errCycLow.fault", fault, 1'b1);
    @(posedge clk_i); #1;
    checkOutput("errCycLow.faultCount", fault_count, modelCount);
    checkOutput("errCycLow.faultCode", fault_code, modelCode);
    checkOutput("errCycLow.faultAdr", fault_adr, modelAdr);

    $display("[TB] master abort");
    bus.m_adr = 32'h6000_0100;
    bus.m_cyc = 1'b1;
    bus.m_stb = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("abort.stbBefore", bus.s_stb, 16'h0040);
    @(posedge clk_i); #1;
    bus.m_cyc = 1'b0;
    bus.m_stb = 1'b0;
    #1;
    checkOutput("abort.stbDropped", bus.s_stb, 16'h0);
    pulses = 0;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      @(negedge clk_i);
      if (fault || bus.m_err || bus.m_ack) pulses++;
    end
    checkOutput("abort.noFault", pulses, 0);
    @(posedge clk_i); #1;
    checkOutput("abort.faultCount", fault_count, modelCount);
    applyStimulus(32'h1000_0000, 1'b0, 32'h0, 4'hF);

    $display("[TB] reset mid-transfer");
    bus.m_adr = 32'h7000_0200;
    bus.m_cyc = 1'b1;
    bus.m_stb = 1'b1;
    @(posedge clk_i); #3;
    checkOutput("rstMid.stbBefore", bus.s_stb, 16'h0080);
    rst_i = 1'b0;
    #1;
    checkOutput("rstMid.sStb", bus.s_stb, 16'h0);
    checkOutput("rstMid.faultCount", fault_count, 8'h00);
    checkOutput("rstMid.faultCode", fault_code, 2'b00);
    checkOutput("rstMid.faultAdr", fault_adr, 32'h0);
    checkOutput("rstMid.mOut", {bus.m_ack, bus.m_err, fault}, 3'b000);
    bus.m_cyc  = 1'b0;
    bus.m_stb  = 1'b0;
    modelCount = '0;
    modelCode  = '0;
    modelAdr   = '0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    applyStimulus(32'h3000_0000, 1'b0, 32'h0, 4'hF);

    $display("[TB] fault counter saturation");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(32'h8000_0000 | 32'(i * 4), 1'b0, 32'h0, 4'hF);
    end
    checkOutput("sat.faultCount", fault_count, 8'hFF);
    checkOutput("queueEmpty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
